// File: rtl/plot_arbiter_if.sv
// plot_arbiter_if: one pixel request channel between a trail drawer
// (master) and plot_arbiter (slave).
//   req     master -> slave  pixel request, held with its data until ack
//   x       master -> slave  pixel x coordinate (on screen 0..159)
//   y       master -> slave  pixel y coordinate (on screen 0..119)
//   colour  master -> slave  pixel colour (r,g,b)
//   ack     slave -> master  one-cycle pulse, pixel consumed
interface plot_arbiter_if;
  logic       req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       ack;

  modport master (output req, x, y, colour, input ack);
  modport slave  (input req, x, y, colour, output ack);
endinterface

// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the vga_adapter plot port between two player trail
// drawers and a built-in full-screen clear sweep. The sweep has priority
// and blocks both players while it runs; player ties go round-robin.
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   clear_start        start a full-screen clear (taken only when not busy)
//   clear_busy         high while the sweep is emitting pixels
//   p1, p2             player pixel request channels (req/ack handshake)
//   x, y, colour, plot registered drive for vga_adapter
module plot_arbiter #(
  parameter int         WIDTH        = 160,
  parameter int         HEIGHT       = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          clear_start,
  output logic          clear_busy,
  plot_arbiter_if.slave p1,
  plot_arbiter_if.slave p2,
  output logic [7:0]    x,
  output logic [6:0]    y,
  output logic [2:0]    colour,
  output logic          plot
);

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic {GRANT_P1, GRANT_P2} grant_t;

  state_t     state, state_next;
  grant_t     last_grant, last_grant_next;
  logic [7:0] sweep_x, sweep_x_next;
  logic [6:0] sweep_y, sweep_y_next;
  logic [7:0] x_next;
  logic [6:0] y_next;
  logic [2:0] colour_next;
  logic       plot_next, busy_next;
  logic       p1_ack_q, p2_ack_q, p1_ack_next, p2_ack_next;

  logic       start_clear, emitting, emit_last;
  logic [7:0] emit_x;
  logic [6:0] emit_y;
  logic       p1_elig, p2_elig, grant_p1, grant_p2;

  assign p1.ack = p1_ack_q;
  assign p2.ack = p2_ack_q;

  // clear_busy is still high in the cycle after the last sweep pixel, so a
  // held clear_start cannot restart the sweep in that handoff cycle.
  assign start_clear = (state == IDLE) && clear_start && !clear_busy;

  // The start cycle itself emits pixel (0,0); the counters then hold the
  // next pixel to emit while in CLEAR.
  assign emitting  = start_clear || (state == CLEAR);
  assign emit_x    = (state == CLEAR) ? sweep_x : 8'd0;
  assign emit_y    = (state == CLEAR) ? sweep_y : 7'd0;
  assign emit_last = (state == CLEAR) && (sweep_x == X_LAST) && (sweep_y == Y_LAST);

  // Masking on the registered ack stops a held request being granted twice.
  assign p1_elig  = p1.req && !p1_ack_q;
  assign p2_elig  = p2.req && !p2_ack_q;
  assign grant_p1 = p1_elig && (!p2_elig || (last_grant == GRANT_P2));
  assign grant_p2 = p2_elig && !grant_p1;

  function automatic logic in_range(input logic [7:0] px, input logic [6:0] py);
    return (px <= X_LAST) && (py <= Y_LAST);
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      last_grant <= GRANT_P2;
      sweep_x    <= '0;
      sweep_y    <= '0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      clear_busy <= 1'b0;
      p1_ack_q   <= 1'b0;
      p2_ack_q   <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      sweep_x    <= sweep_x_next;
      sweep_y    <= sweep_y_next;
      x          <= x_next;
      y          <= y_next;
      colour     <= colour_next;
      plot       <= plot_next;
      clear_busy <= busy_next;
      p1_ack_q   <= p1_ack_next;
      p2_ack_q   <= p2_ack_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_clear) state_next = CLEAR;
      CLEAR:   if (emit_last)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    x_next          = x;
    y_next          = y;
    colour_next     = colour;
    plot_next       = 1'b0;
    busy_next       = 1'b0;
    p1_ack_next     = 1'b0;
    p2_ack_next     = 1'b0;
    last_grant_next = last_grant;
    sweep_x_next    = sweep_x;
    sweep_y_next    = sweep_y;
    if (emitting) begin
      x_next      = emit_x;
      y_next      = emit_y;
      colour_next = CLEAR_COLOUR;
      plot_next   = 1'b1;
      busy_next   = 1'b1;
      // x-major order; after the last pixel the counters return to (0,0)
      if (emit_x == X_LAST) begin
        sweep_x_next = 8'd0;
        sweep_y_next = (emit_y == Y_LAST) ? 7'd0 : emit_y + 7'd1;
      end else begin
        sweep_x_next = emit_x + 8'd1;
        sweep_y_next = emit_y;
      end
    end else if (grant_p1) begin
      x_next          = p1.x;
      y_next          = p1.y;
      colour_next     = p1.colour;
      plot_next       = in_range(p1.x, p1.y);
      p1_ack_next     = 1'b1;
      last_grant_next = GRANT_P1;
    end else if (grant_p2) begin
      x_next          = p2.x;
      y_next          = p2.y;
      colour_next     = p2.colour;
      plot_next       = in_range(p2.x, p2.y);
      p2_ack_next     = 1'b1;
      last_grant_next = GRANT_P2;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb_plot_arbiter: self-checking bench for plot_arbiter. Directed vector
// table for the handshake/arbitration basics, hand-written sequences for
// reset, the full clear sweep and reset mid-clear, then randomized traffic
// checked against a pixel-index reference model.
module tb_plot_arbiter;
  localparam int WIDTH  = 160;
  localparam int HEIGHT = 120;
  localparam int PIXELS = WIDTH * HEIGHT;

  typedef struct {
    logic       clr;
    logic       r1;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] c1;
    logic       r2;
    logic [7:0] x2;
    logic [6:0] y2;
    logic [2:0] c2;
  } ins_t;

  typedef struct {
    logic       ack1;
    logic       ack2;
    logic       plot;
    logic       busy;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } outs_t;

  typedef struct {
    ins_t  in;
    outs_t out;
  } vec_t;

  logic       clock = 1'b0;
  logic       resetn;
  logic       clear_start;
  logic       clear_busy;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  plot_arbiter_if p1_if ();
  plot_arbiter_if p2_if ();

  plot_arbiter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .CLEAR_COLOUR(3'b000)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .clear_start(clear_start),
    .clear_busy (clear_busy),
    .p1         (p1_if),
    .p2         (p2_if),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // reference model state
  outs_t m;
  int    m_pending;
  int    m_idx;
  int    m_last;

  vec_t  tbl [15];

  function automatic ins_t mk_in(logic r1, logic [7:0] x1, logic [6:0] y1, logic [2:0] c1,
                                 logic r2, logic [7:0] x2, logic [6:0] y2, logic [2:0] c2);
    ins_t s;
    s.clr = 1'b0;
    s.r1 = r1; s.x1 = x1; s.y1 = y1; s.c1 = c1;
    s.r2 = r2; s.x2 = x2; s.y2 = y2; s.c2 = c2;
    return s;
  endfunction

  function automatic outs_t mk_out(logic a1, logic a2, logic pl, logic [7:0] ox,
                                   logic [6:0] oy, logic [2:0] oc);
    outs_t o;
    o.ack1 = a1; o.ack2 = a2; o.plot = pl; o.busy = 1'b0;
    o.x = ox; o.y = oy; o.colour = oc;
    return o;
  endfunction

  function automatic outs_t zero_out();
    return mk_out(1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0);
  endfunction

  task automatic apply_stimulus(input ins_t s);
    clear_start   = s.clr;
    p1_if.req     = s.r1;
    p1_if.x       = s.x1;
    p1_if.y       = s.y1;
    p1_if.colour  = s.c1;
    p2_if.req     = s.r2;
    p2_if.x       = s.x2;
    p2_if.y       = s.y2;
    p2_if.colour  = s.c2;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input outs_t e);
    check_field({tag, ".p1_ack"},     32'(p1_if.ack),  32'(e.ack1));
    check_field({tag, ".p2_ack"},     32'(p2_if.ack),  32'(e.ack2));
    check_field({tag, ".plot"},       32'(plot),       32'(e.plot));
    check_field({tag, ".clear_busy"}, 32'(clear_busy), 32'(e.busy));
    check_field({tag, ".x"},          32'(x),          32'(e.x));
    check_field({tag, ".y"},          32'(y),          32'(e.y));
    check_field({tag, ".colour"},     32'(colour),     32'(e.colour));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    apply_stimulus(mk_in(1'b0, 8'd0, 7'd0, 3'd0, 1'b0, 8'd0, 7'd0, 3'd0));
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    m         = zero_out();
    m_pending = 0;
    m_idx     = 0;
    m_last    = 2;
  endtask

  // Reference model: the sweep is a pixel index 0..PIXELS-1 turned into
  // (x,y) with div/mod; players are granted by eligibility and "whoever
  // did not win last".
  task automatic model_step(input ins_t s);
    outs_t n;
    logic  e1, e2;
    int    win;
    n = m;
    n.plot = 1'b0; n.ack1 = 1'b0; n.ack2 = 1'b0; n.busy = 1'b0;
    if (m_pending > 0 || (s.clr && !m.busy)) begin
      if (m_pending == 0) begin
        m_idx     = 0;
        m_pending = PIXELS;
      end
      n.x      = 8'(m_idx % WIDTH);
      n.y      = 7'(m_idx / WIDTH);
      n.colour = 3'd0;
      n.plot   = 1'b1;
      n.busy   = 1'b1;
      m_idx++;
      m_pending--;
    end else begin
      e1  = s.r1 && !m.ack1;
      e2  = s.r2 && !m.ack2;
      win = 0;
      if (e1 && e2)  win = (m_last == 1) ? 2 : 1;
      else if (e1)   win = 1;
      else if (e2)   win = 2;
      if (win == 1) begin
        n.x = s.x1; n.y = s.y1; n.colour = s.c1; n.ack1 = 1'b1;
        n.plot = (int'(s.x1) < WIDTH) && (int'(s.y1) < HEIGHT);
        m_last = 1;
      end else if (win == 2) begin
        n.x = s.x2; n.y = s.y2; n.colour = s.c2; n.ack2 = 1'b1;
        n.plot = (int'(s.x2) < WIDTH) && (int'(s.y2) < HEIGHT);
        m_last = 2;
      end
    end
    m = n;
  endtask

  initial begin
    ins_t  s;
    ins_t  none_in;
    ins_t  both_in;
    ins_t  p1a_in;
    outs_t e;

    none_in = mk_in(1'b0, 8'd0,   7'd0,   3'd0, 1'b0, 8'd0, 7'd0, 3'd0);
    both_in = mk_in(1'b1, 8'd5,   7'd5,   3'd1, 1'b1, 8'd6, 7'd6, 3'd2);
    p1a_in  = mk_in(1'b1, 8'd10,  7'd20,  3'd4, 1'b0, 8'd0, 7'd0, 3'd0);

    tbl[0]  = '{both_in, mk_out(1'b1, 1'b0, 1'b1, 8'd5,   7'd5,   3'd1)};
    tbl[1]  = '{both_in, mk_out(1'b0, 1'b1, 1'b1, 8'd6,   7'd6,   3'd2)};
    tbl[2]  = '{both_in, mk_out(1'b1, 1'b0, 1'b1, 8'd5,   7'd5,   3'd1)};
    tbl[3]  = '{both_in, mk_out(1'b0, 1'b1, 1'b1, 8'd6,   7'd6,   3'd2)};
    tbl[4]  = '{none_in, mk_out(1'b0, 1'b0, 1'b0, 8'd6,   7'd6,   3'd2)};
    tbl[5]  = '{p1a_in,  mk_out(1'b1, 1'b0, 1'b1, 8'd10,  7'd20,  3'd4)};
    tbl[6]  = '{p1a_in,  mk_out(1'b0, 1'b0, 1'b0, 8'd10,  7'd20,  3'd4)};
    tbl[7]  = '{p1a_in,  mk_out(1'b1, 1'b0, 1'b1, 8'd10,  7'd20,  3'd4)};
    tbl[8]  = '{none_in, mk_out(1'b0, 1'b0, 1'b0, 8'd10,  7'd20,  3'd4)};
    tbl[9]  = '{mk_in(1'b1, 8'd160, 7'd0, 3'd7, 1'b0, 8'd0, 7'd0, 3'd0),
                mk_out(1'b1, 1'b0, 1'b0, 8'd160, 7'd0,   3'd7)};
    tbl[10] = '{none_in, mk_out(1'b0, 1'b0, 1'b0, 8'd160, 7'd0,   3'd7)};
    tbl[11] = '{mk_in(1'b1, 8'd0, 7'd120, 3'd5, 1'b0, 8'd0, 7'd0, 3'd0),
                mk_out(1'b1, 1'b0, 1'b0, 8'd0,   7'd120, 3'd5)};
    tbl[12] = '{none_in, mk_out(1'b0, 1'b0, 1'b0, 8'd0,   7'd120, 3'd5)};
    tbl[13] = '{mk_in(1'b1, 8'd159, 7'd119, 3'd6, 1'b0, 8'd0, 7'd0, 3'd0),
                mk_out(1'b1, 1'b0, 1'b1, 8'd159, 7'd119, 3'd6)};
    tbl[14] = '{none_in, mk_out(1'b0, 1'b0, 1'b0, 8'd159, 7'd119, 3'd6)};

    // reset held with every request and clear_start active
    resetn = 1'b0;
    s = mk_in(1'b1, 8'd33, 7'd44, 3'd5, 1'b1, 8'd55, 7'd66, 3'd6);
    s.clr = 1'b1;
    apply_stimulus(s);
    #3;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("reset%0d", i), zero_out());
      step();
    end
    check_output("reset_end", zero_out());
    apply_stimulus(none_in);
    @(negedge clock);
    resetn = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(tbl[i].in);
      step();
      check_output($sformatf("vec%0d", i), tbl[i].out);
    end

    $display("[TB] full clear with P2 waiting");
    check_field("pre_clear.clear_busy", 32'(clear_busy), 32'd0);
    s = mk_in(1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd30, 7'd40, 3'd3);
    s.clr = 1'b1;
    apply_stimulus(s);
    step();
    s.clr = 1'b0;
    apply_stimulus(s);
    for (int k = 0; k < PIXELS; k++) begin
      e = mk_out(1'b0, 1'b0, 1'b1, 8'(k % WIDTH), 7'(k / WIDTH), 3'd0);
      e.busy = 1'b1;
      check_output($sformatf("clr%0d", k), e);
      // mid-sweep clear_start must not restart the sweep
      clear_start = (k == 100);
      step();
    end
    check_output("handoff", mk_out(1'b0, 1'b1, 1'b1, 8'd30, 7'd40, 3'd3));
    apply_stimulus(none_in);
    step();
    check_output("after_handoff", mk_out(1'b0, 1'b0, 1'b0, 8'd30, 7'd40, 3'd3));

    $display("[TB] reset in the middle of a clear");
    s = none_in;
    s.clr = 1'b1;
    apply_stimulus(s);
    step();
    apply_stimulus(none_in);
    for (int k = 0; k < 500; k++) step();
    e = mk_out(1'b0, 1'b0, 1'b1, 8'd20, 7'd3, 3'd0);
    e.busy = 1'b1;
    check_output("pix500", e);
    #2;
    resetn = 1'b0;
    #1;
    check_output("mid_reset", zero_out());
    @(negedge clock);
    resetn = 1'b1;
    apply_stimulus(mk_in(1'b1, 8'd7, 7'd8, 3'd2, 1'b0, 8'd0, 7'd0, 3'd0));
    step();
    check_output("post_reset_grant", mk_out(1'b1, 1'b0, 1'b1, 8'd7, 7'd8, 3'd2));
    apply_stimulus(none_in);
    for (int k = 0; k < 20; k++) begin
      step();
      check_output($sformatf("no_resume%0d", k), mk_out(1'b0, 1'b0, 1'b0, 8'd7, 7'd8, 3'd2));
    end

    $display("[TB] randomized traffic against reference model");
    do_reset();
    for (int i = 0; i < 3000 + PIXELS; i++) begin
      s.r1  = 1'($urandom_range(0, 1));
      s.x1  = 8'($urandom_range(0, 175));
      s.y1  = 7'($urandom_range(0, 127));
      s.c1  = 3'($urandom);
      s.r2  = 1'($urandom_range(0, 1));
      s.x2  = 8'($urandom_range(0, 175));
      s.y2  = 7'($urandom_range(0, 127));
      s.c2  = 3'($urandom);
      s.clr = (i == 1000) || (m_pending > 0 && $urandom_range(0, 299) == 0);
      apply_stimulus(s);
      model_step(s);
      step();
      check_output($sformatf("rand%0d", i), m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/plot_arbiter.md
# plot_arbiter

Shares the single `vga_adapter` plot port (160x120, 3-bit colour) between two player trail drawers and a built-in full-screen clear engine. The arbiter takes per-player pixel requests through a req/ack handshake and resolves ties round-robin. The clear sweep takes priority over both players and blocks them while it runs. The arbiter sits between the game logic and `vga_adapter` and drives that adapter's `x`, `y`, `colour` and `plot` inputs directly from registers.

## Interface
- `WIDTH`, 160: screen width in pixels; x range 0..WIDTH-1.
- `HEIGHT`, 120: screen height in pixels; y range 0..HEIGHT-1.
- `CLEAR_COLOUR`, 3'b000: colour written by the clear sweep.

Ports:
- `clock`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  asynchronous, active-low reset.
- `clear_start`  in  1  start a full-screen clear; sampled only when not busy.
- `clear_busy`  out  1  high while the sweep is emitting pixels.
- `p1_req`  in  1  player 1 pixel request.
- `p1_x`  in  8  player 1 pixel x coordinate.
- `p1_y`  in  7  player 1 pixel y coordinate.
- `p1_colour`  in  3  player 1 pixel colour (r,g,b).
- `p1_ack`  out  1  one-cycle pulse: player 1 pixel consumed.
- `p2_req`, `p2_x`, `p2_y`, `p2_colour`, `p2_ack`: identical to the player 1 ports, for player 2.
- `x`  out  8  to `vga_adapter.x`.
- `y`  out  7  to `vga_adapter.y`.
- `colour`  out  3  to `vga_adapter.colour`.
- `plot`  out  1  to `vga_adapter.plot`.

## Operation
- States: IDLE (arbitrate players) and CLEAR (sweep). All outputs are registered.
- **IDLE to CLEAR:** `clear_start`=1 in IDLE moves the block to CLEAR. `clear_start` has priority over any player request in the same cycle; the players receive no ack that cycle.
- **CLEAR sweep:**
  - One pixel per cycle, x inner loop 0..WIDTH-1, y outer loop 0..HEIGHT-1.
  - `colour`=`CLEAR_COLOUR`, `plot`=1 for every pixel.
  - After (WIDTH-1, HEIGHT-1) has been emitted, return to IDLE.
  - `clear_start` is ignored while in CLEAR; the sweep does not restart.
- **Player arbitration (IDLE only):**
  - Requester N is eligible if `pN_req`=1 and `pN_ack` is not high this cycle. Masking on ack prevents a held request from being granted twice.
  - One eligible requester: grant it.
  - Both eligible: grant the requester not granted last. The `last_grant` register resets to P2, so P1 wins the first tie.
- **Grant in cycle t:** in cycle t+1, `x`/`y`/`colour` carry the winner's data, `plot`=1, and `pN_ack`=1.
- **Out-of-range pixel:** if granted `pN_x`≥WIDTH or `pN_y`≥HEIGHT, the ack still pulses but `plot`=0 (pixel dropped).
- **No grant:** `plot`=0. `x`/`y`/`colour` hold their previous values.
- **Requester contract:**
  - Hold req and data stable until ack.
  - If req is still high in the cycle after ack, that is a new request.
  - One requester alone gets at most one pixel per 2 cycles; two requesters together get one pixel per cycle in total.

## Timing
- **Reset** (async, `resetn`=0):
  - `x`=0, `y`=0, `colour`=0, `plot`=0, `p1_ack`=0, `p2_ack`=0, `clear_busy`=0.
  - State IDLE, sweep counters 0, `last_grant`=P2.
- **Reset mid-clear:** the sweep is aborted immediately and outputs take their reset values. No resume after reset.
- **Grant latency:** 1 cycle from the sampled req to plot/ack.
- **Clear timing:** `clear_start` sampled in cycle t.
  - t+1: `clear_busy`=1, `plot`=1, (x,y)=(0,0).
  - t+k: pixel k-1 in x-major order.
  - t+19200: (159,119); `clear_busy` still 1.
  - t+19201: `clear_busy`=0.
- **Handoff after clear:** player requests sampled in cycle t+19200 may be granted, with plot/ack appearing at t+19201. This gives back-to-back plots with no gap.
- **Wrap:** x wraps from WIDTH-1 to 0 while y increments. Counters are wide enough that neither wraps past HEIGHT-1.

## Test plan
- **Reset:** assert `resetn`=0 with all requests active. All outputs read 0 and stay 0 until release.
- **Single requester:** P1 holds req with (10,20,3'b100). `p1_ack` and plot with (10,20,4) appear 1 cycle later, then repeat every 2nd cycle. P2 stays idle with `p2_ack`=0.
- **Both requesting:** both hold req, P1 (5,5,1) and P2 (6,6,2). Plots alternate P1,P2,P1,... every cycle, starting with P1. Each ack pulses on its own pixel only.
- **Clear with a waiting requester:** `clear_start` pulses while P2 is requesting. Exactly 19200 plots with colour 000 in order (0,0),...,(159,0),(0,1),...,(159,119). `clear_busy` is 1 for exactly 19200 cycles. `p2_ack` stays 0 throughout, and P2's pixel is plotted in the cycle `clear_busy` falls.
- **Out-of-range pixel:** P1 requests (160,0), then (0,120). Ack pulses each time with `plot`=0. A following request (159,119) plots normally.
- **Reset mid-clear:** pulse `resetn` low at sweep pixel 500. `clear_busy`=0 and `plot`=0 at once. After release, a P1 request is granted in 1 cycle and no clear pixels follow.
